// File: rtl/audio_tone_gen_if.sv
// Sample/config bus of the audio tone generator: codec sample strobe, config load port, sample output.
interface audio_tone_gen_if #(
    parameter int PHASE_W = 32,
    parameter int AMP_W   = 24,
    parameter int OUT_W   = 32
);
    logic                     sample_tick;
    logic                     cfg_load;
    logic [PHASE_W-1:0]       cfg_inc;
    logic [AMP_W-1:0]         cfg_amp;
    logic [1:0]               cfg_mode;
    logic                     cfg_busy;
    logic signed [OUT_W-1:0]  out;
    logic                     out_valid;

    modport master (
        output sample_tick, cfg_load, cfg_inc, cfg_amp, cfg_mode,
        input  cfg_busy, out, out_valid
    );

    modport slave (
        input  sample_tick, cfg_load, cfg_inc, cfg_amp, cfg_mode,
        output cfg_busy, out, out_valid
    );
endinterface

// File: rtl/audio_tone_gen.sv
// Phase-accumulator tone generator (square, saw, triangle, silence); new settings take effect at a phase wrap.
// Build option TONE_GEN_TRIANGLE_EN: defined builds the triangle fold, undefined makes mode 2 a square wave.
module audio_tone_gen #(
    parameter int                 PHASE_W     = 32,
    parameter int                 NORM_W      = 16,
    parameter int                 AMP_W       = 24,
    parameter int                 OUT_W       = 32,
    parameter logic [PHASE_W-1:0] DEFAULT_INC = PHASE_W'(37_795),
    parameter logic [AMP_W-1:0]   DEFAULT_AMP = AMP_W'(10_000_000)
) (
    input  logic            CLOCK_50,
    input  logic            reset,
    audio_tone_gen_if.slave bus
);

`ifdef TONE_GEN_TRIANGLE_EN
    localparam int SNAP_W = NORM_W + 1;
`else
    localparam int SNAP_W = NORM_W;
`endif
    localparam int PROD_W = NORM_W + AMP_W + 1;

    localparam logic [1:0] MODE_SQUARE  = 2'd0;
    localparam logic [1:0] MODE_SAW     = 2'd1;
    localparam logic [1:0] MODE_TRI     = 2'd2;
    localparam logic [1:0] MODE_SILENCE = 2'd3;

    typedef enum logic {
        CFG_IDLE,
        CFG_PENDING
    } cfg_state_t;

    function automatic logic signed [NORM_W-1:0] norm_saw(input logic [SNAP_W-1:0] p);
        return {~p[SNAP_W-1], p[SNAP_W-2 -: NORM_W-1]};
    endfunction

`ifdef TONE_GEN_TRIANGLE_EN
    // Fold the second half period back down so the wave rises, then falls.
    function automatic logic signed [NORM_W-1:0] norm_tri(input logic [SNAP_W-1:0] p);
        logic [NORM_W-1:0] tu;
        tu = p[SNAP_W-1] ? ~p[NORM_W-1:0] : p[NORM_W-1:0];
        return {~tu[NORM_W-1], tu[NORM_W-2:0]};
    endfunction
`endif

    function automatic logic signed [OUT_W-1:0] scale_norm(input logic signed [NORM_W-1:0] norm,
                                                           input logic [AMP_W-1:0]         amp);
        logic signed [PROD_W-1:0] prod;
        prod = PROD_W'(norm) * PROD_W'($signed({1'b0, amp}));
        return OUT_W'(prod >>> (NORM_W - 1));
    endfunction

    function automatic logic signed [OUT_W-1:0] square_val(input logic msb, input logic [AMP_W-1:0] amp);
        logic signed [OUT_W-1:0] mag;
        mag = OUT_W'($signed({1'b0, amp}));
        return msb ? mag : -mag;
    endfunction

    logic [PHASE_W-1:0]      phase_q, phase_d;
    logic [PHASE_W-1:0]      inc_q, inc_d;
    logic [AMP_W-1:0]        amp_q, amp_d;
    logic [1:0]              mode_q, mode_d;
    logic [PHASE_W-1:0]      pend_inc_q, pend_inc_d;
    logic [AMP_W-1:0]        pend_amp_q, pend_amp_d;
    logic [1:0]              pend_mode_q, pend_mode_d;
    cfg_state_t              cfg_state_q, cfg_state_d;
    logic [PHASE_W:0]        acc_sum;
    logic                    apply;

    logic [SNAP_W-1:0]       phase_p1_q, phase_p1_d;
    logic [AMP_W-1:0]        amp_p1_q, amp_p1_d;
    logic [1:0]              mode_p1_q, mode_p1_d;
    logic                    vld_p1_q, vld_p1_d;
    logic signed [OUT_W-1:0] out_p2_q, out_p2_d;
    logic                    vld_p2_q, vld_p2_d;

    // Config FSM: pending settings move to active on a wrap, or immediately when the tone is frozen or silent.
    always_comb begin
        acc_sum     = {1'b0, phase_q} + {1'b0, inc_q};
        apply       = (cfg_state_q == CFG_PENDING) &&
                      (acc_sum[PHASE_W] || (inc_q == '0) || (mode_q == MODE_SILENCE));
        cfg_state_d = cfg_state_q;
        unique case (cfg_state_q)
            CFG_IDLE:    if (bus.cfg_load) cfg_state_d = CFG_PENDING;
            CFG_PENDING: if (apply && !bus.cfg_load) cfg_state_d = CFG_IDLE;
            default:     cfg_state_d = CFG_IDLE;
        endcase
    end

    always_comb begin
        phase_d     = acc_sum[PHASE_W-1:0];
        inc_d       = inc_q;
        amp_d       = amp_q;
        mode_d      = mode_q;
        pend_inc_d  = pend_inc_q;
        pend_amp_d  = pend_amp_q;
        pend_mode_d = pend_mode_q;
        if (apply) begin
            inc_d  = pend_inc_q;
            amp_d  = pend_amp_q;
            mode_d = pend_mode_q;
        end
        // A load on the apply cycle queues behind the set being applied.
        if (bus.cfg_load) begin
            pend_inc_d  = bus.cfg_inc;
            pend_amp_d  = bus.cfg_amp;
            pend_mode_d = bus.cfg_mode;
        end
    end

    // Stage p1: snapshot phase and active settings together on the sample tick.
    always_comb begin
        phase_p1_d = phase_p1_q;
        amp_p1_d   = amp_p1_q;
        mode_p1_d  = mode_p1_q;
        vld_p1_d   = bus.sample_tick;
        if (bus.sample_tick) begin
            phase_p1_d = phase_q[PHASE_W-1 -: SNAP_W];
            amp_p1_d   = amp_q;
            mode_p1_d  = mode_q;
        end
    end

    // Stage p2: shape and scale the snapshot into the output sample.
    always_comb begin
        vld_p2_d = vld_p1_q;
        out_p2_d = out_p2_q;
        if (vld_p1_q) begin
            unique case (mode_p1_q)
                MODE_SQUARE:  out_p2_d = square_val(phase_p1_q[SNAP_W-1], amp_p1_q);
                MODE_SAW:     out_p2_d = scale_norm(norm_saw(phase_p1_q), amp_p1_q);
`ifdef TONE_GEN_TRIANGLE_EN
                MODE_TRI:     out_p2_d = scale_norm(norm_tri(phase_p1_q), amp_p1_q);
`else
                MODE_TRI:     out_p2_d = square_val(phase_p1_q[SNAP_W-1], amp_p1_q);
`endif
                MODE_SILENCE: out_p2_d = '0;
                default:      out_p2_d = '0;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            phase_q     <= '0;
            inc_q       <= DEFAULT_INC;
            amp_q       <= DEFAULT_AMP;
            mode_q      <= MODE_SQUARE;
            cfg_state_q <= CFG_IDLE;
            vld_p1_q    <= 1'b0;
            vld_p2_q    <= 1'b0;
            out_p2_q    <= '0;
        end else begin
            phase_q     <= phase_d;
            inc_q       <= inc_d;
            amp_q       <= amp_d;
            mode_q      <= mode_d;
            cfg_state_q <= cfg_state_d;
            vld_p1_q    <= vld_p1_d;
            vld_p2_q    <= vld_p2_d;
            out_p2_q    <= out_p2_d;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        pend_inc_q  <= pend_inc_d;
        pend_amp_q  <= pend_amp_d;
        pend_mode_q <= pend_mode_d;
        phase_p1_q  <= phase_p1_d;
        amp_p1_q    <= amp_p1_d;
        mode_p1_q   <= mode_p1_d;
    end

    assign bus.cfg_busy  = (cfg_state_q == CFG_PENDING);
    assign bus.out       = out_p2_q;
    assign bus.out_valid = vld_p2_q;

endmodule

// File: tb/tb_audio_tone_gen.sv
// Bench for audio_tone_gen: reference model feeding a sample scoreboard, a frozen-phase vector table, corner sequences.
`timescale 1ns/1ps
module tb_audio_tone_gen;
    // Faster default increment (wrap every 64 cycles) keeps wrap-driven sequences short.
    localparam logic [31:0] TB_DEF_INC = 32'h0400_0000;
    localparam logic [23:0] TB_DEF_AMP = 24'd10_000_000;

    logic CLOCK_50 = 1'b0;
    logic reset;
    always #10 CLOCK_50 = ~CLOCK_50;

    audio_tone_gen_if #(.PHASE_W(32), .AMP_W(24), .OUT_W(32)) bus ();

    audio_tone_gen #(
        .PHASE_W(32), .NORM_W(16), .AMP_W(24), .OUT_W(32),
        .DEFAULT_INC(TB_DEF_INC), .DEFAULT_AMP(TB_DEF_AMP)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset(reset),
        .bus(bus)
    );

    typedef struct { longint val; int due; } sb_t;
    typedef struct { logic [31:0] ph; logic [23:0] amp; logic [1:0] mode; longint exp; } vec_t;

    sb_t         sbq[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_err = 0;
    longint      last_out = 0;
    logic [31:0] m_phase, m_inc, m_pinc;
    logic [23:0] m_amp, m_pamp;
    logic [1:0]  m_mode, m_pmode;
    logic        m_busy, m_rst_d;
    logic [32:0] m_sum;
    logic        m_apply;

    function automatic longint exp_sample(input logic [31:0] ph, input logic [1:0] md, input logic [23:0] am);
        longint a, n;
        a = longint'(am);
        n = 0;
        if (md == 2'd3) return 0;
        if (md == 2'd0) return ph[31] ? a : -a;
        if (md == 2'd1) begin
            n = longint'(ph[31:16]) - 32768;
        end else begin
`ifdef TONE_GEN_TRIANGLE_EN
            longint t;
            t = longint'(ph[31:15]);
            if (t >= 65536) t = 131071 - t;
            n = t - 32768;
`else
            return ph[31] ? a : -a;
`endif
        end
        return (n * a) >>> 15;
    endfunction

    assign m_sum   = {1'b0, m_phase} + {1'b0, m_inc};
    assign m_apply = m_busy && (m_sum[32] || (m_inc == 32'd0) || (m_mode == 2'd3));

    always @(posedge CLOCK_50) begin
        cyc     <= cyc + 1;
        m_rst_d <= reset;
        if (reset) begin
            m_phase <= 32'd0;
            m_inc   <= TB_DEF_INC;
            m_amp   <= TB_DEF_AMP;
            m_mode  <= 2'd0;
            m_busy  <= 1'b0;
            sbq.delete();
        end else begin
            m_phase <= m_sum[31:0];
            if (m_apply) begin
                m_inc  <= m_pinc;
                m_amp  <= m_pamp;
                m_mode <= m_pmode;
            end
            if (bus.cfg_load) begin
                m_pinc  <= bus.cfg_inc;
                m_pamp  <= bus.cfg_amp;
                m_pmode <= bus.cfg_mode;
            end
            m_busy <= bus.cfg_load || (m_busy && !m_apply);
            if (bus.sample_tick) sbq.push_back('{exp_sample(m_phase, m_mode, m_amp), cyc + 2});
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic sb_check();
        sb_t e;
        if (m_rst_d) last_out = 0;
        if (bus.out_valid) begin
            if (sbq.size() == 0) begin
                chk("sb_unexpected_valid", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk("sb_sample", longint'(bus.out), e.val);
                chk("sb_latency", cyc, e.due);
                last_out = e.val;
            end
        end else begin
            chk("sb_hold", longint'(bus.out), last_out);
            if (sbq.size() > 0 && sbq[0].due <= cyc) begin
                e = sbq.pop_front();
                chk("sb_missing_valid", 0, 1);
            end
        end
        chk("sb_busy", longint'(bus.cfg_busy), longint'(m_busy));
    endtask

    task automatic step();
        @(negedge CLOCK_50);
        sb_check();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic wait_idle(input string name, input int maxc);
        int n;
        n = 0;
        while (bus.cfg_busy && n < maxc) begin
            step();
            n++;
        end
        chk(name, longint'(bus.cfg_busy), 0);
    endtask

    task automatic wait_model_phase_zero(input string name);
        int n;
        n = 0;
        while (m_phase != 32'd0 && n < 80) begin
            step();
            n++;
        end
        if (n >= 80) chk(name, n, 0);
    endtask

    task automatic load(input logic [31:0] inc, input logic [23:0] amp, input logic [1:0] mode);
        bus.cfg_load = 1'b1;
        bus.cfg_inc  = inc;
        bus.cfg_amp  = amp;
        bus.cfg_mode = mode;
    endtask

    vec_t        tbl[11];
    logic [31:0] cur_phase;
    int          n;

    initial begin
        tbl[0]  = '{32'h8000_0000, 24'd1000,     2'd0, 1000};
        tbl[1]  = '{32'h4000_0000, 24'd1000,     2'd0, -1000};
        tbl[2]  = '{32'h0000_0000, 24'd1000,     2'd1, -1000};
        tbl[3]  = '{32'hFFFF_FFFF, 24'd1000,     2'd1, 999};
        tbl[4]  = '{32'h8000_0000, 24'd12345,    2'd1, 0};
        tbl[5]  = '{32'h4000_0000, 24'hFF_FFFF,  2'd1, -8388608};
        tbl[6]  = '{32'h0000_0000, 24'd32768,    2'd2, -32768};
`ifdef TONE_GEN_TRIANGLE_EN
        tbl[7]  = '{32'h8000_0000, 24'd32768,    2'd2, 32767};
        tbl[8]  = '{32'h4000_0000, 24'd1000,     2'd2, 0};
        tbl[9]  = '{32'hC000_0000, 24'd1000,     2'd2, -1};
`else
        tbl[7]  = '{32'h8000_0000, 24'd32768,    2'd2, 32768};
        tbl[8]  = '{32'h4000_0000, 24'd1000,     2'd2, -1000};
        tbl[9]  = '{32'hC000_0000, 24'd1000,     2'd2, 1000};
`endif
        tbl[10] = '{32'h8000_0000, 24'd5000,     2'd3, 0};

        reset = 1'b1;
        bus.sample_tick = 1'b0;
        bus.cfg_load = 1'b0;
        bus.cfg_inc = 32'd0;
        bus.cfg_amp = 24'd0;
        bus.cfg_mode = 2'd0;
        step();
        step();
        chk("rst_out", longint'(bus.out), 0);
        chk("rst_valid", longint'(bus.out_valid), 0);
        chk("rst_busy", longint'(bus.cfg_busy), 0);

        // Defaults: square at default amplitude, phase starting from 0.
        reset = 1'b0;
        bus.sample_tick = 1'b1;
        step();
        bus.sample_tick = 1'b0;
        step();
        chk("dflt_first_valid", longint'(bus.out_valid), 1);
        chk("dflt_first_out", longint'(bus.out), -10_000_000);
        for (int i = 0; i < 9; i++) begin
            bus.sample_tick = 1'b1;
            step();
            bus.sample_tick = 1'b0;
            repeat (6) step();
        end

        // Freeze the phase: load inc=0 in silence, applied at the next wrap (phase lands on 0).
        load(32'd0, 24'd1, 2'd3);
        step();
        bus.cfg_load = 1'b0;
        chk("freeze_busy_rise", longint'(bus.cfg_busy), 1);
        wait_idle("freeze_busy_clear", 100);
        cur_phase = 32'd0;

        // Vector table: park the phase at an exact value, then take one sample.
        for (int r = 0; r < 11; r++) begin
            load(tbl[r].ph - cur_phase, tbl[r].amp, 2'd3);
            step();
            load(32'd0, tbl[r].amp, tbl[r].mode);
            step();
            chk("tbl_busy_on_apply_load", longint'(bus.cfg_busy), 1);
            bus.cfg_load = 1'b0;
            step();
            chk("tbl_busy_clear", longint'(bus.cfg_busy), 0);
            step();
            bus.sample_tick = 1'b1;
            step();
            bus.sample_tick = 1'b0;
            step();
            chk($sformatf("tbl%0d_valid", r), longint'(bus.out_valid), 1);
            chk($sformatf("tbl%0d_out", r), longint'(bus.out), tbl[r].exp);
            cur_phase = tbl[r].ph;
        end

        // Saw ramp with a sample every cycle.
        load(32'h1000_0000, 24'd1000, 2'd1);
        step();
        bus.cfg_load = 1'b0;
        bus.sample_tick = 1'b1;
        repeat (40) step();

        // Two loads while busy: only the second one reaches the output.
        wait_model_phase_zero("two_load_align");
        load(32'h0800_0000, 24'd500, 2'd0);
        step();
        chk("two_load_busy1", longint'(bus.cfg_busy), 1);
        load(32'h0800_0000, 24'd32768, 2'd2);
        step();
        bus.cfg_load = 1'b0;
        chk("two_load_busy2", longint'(bus.cfg_busy), 1);
        wait_idle("two_load_clear", 40);
        step();
        step();
        chk("two_load_first_out", longint'(bus.out), -32768);
        repeat (36) step();

        // Load landing on the apply cycle: old pending applies, new one waits for the next wrap.
        load(32'h0800_0000, 24'd2000, 2'd0);
        step();
        bus.cfg_load = 1'b0;
        n = 0;
        while (!m_apply && n < 64) begin
            step();
            n++;
        end
        if (n >= 64) chk("simul_wait_timeout", n, 0);
        load(32'h0800_0000, 24'd3000, 2'd1);
        step();
        bus.cfg_load = 1'b0;
        chk("simul_busy_held", longint'(bus.cfg_busy), 1);
        wait_idle("simul_clear", 64);
        step();
        step();
        chk("simul_second_out", longint'(bus.out), -3000);
        repeat (8) step();

        // Reset while a config is pending and samples are in flight.
        wait_model_phase_zero("mid_rst_align");
        load(32'h0400_0000, 24'd777, 2'd1);
        step();
        bus.cfg_load = 1'b0;
        step();
        chk("mid_rst_busy_before", longint'(bus.cfg_busy), 1);
        reset = 1'b1;
        step();
        chk("mid_rst_out", longint'(bus.out), 0);
        chk("mid_rst_valid", longint'(bus.out_valid), 0);
        chk("mid_rst_busy", longint'(bus.cfg_busy), 0);
        reset = 1'b0;
        step();
        bus.sample_tick = 1'b0;
        step();
        chk("mid_rst_restart_out", longint'(bus.out), -10_000_000);
        repeat (33) step();
        bus.sample_tick = 1'b1;
        step();
        bus.sample_tick = 1'b0;
        step();
        chk("mid_rst_half_period_out", longint'(bus.out), 10_000_000);
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/audio_tone_gen.md
# audio_tone_gen

Parametrised multi-waveform tone generator for the audio demo datapath. A phase accumulator, clocked at CLOCK_50, produces one of four waveforms: square, sawtooth, triangle or silence. Each waveform has a programmable frequency and amplitude, and configuration changes are glitch-free, taking effect at a phase wrap. The block emits one signed sample per codec sample strobe, feeding the audio codec serializer's left/right sample inputs.

## Interface
- PHASE_W, 32: phase accumulator width.
- NORM_W, 16: normalised waveform width (signed).
- AMP_W, 24: amplitude width (unsigned).
- OUT_W, 32: output sample width (signed, two's complement).
- DEFAULT_INC, 37_795: reset phase increment (440 Hz = 440·2^32/50e6).
- DEFAULT_AMP, 10_000_000: reset amplitude.
- CLOCK_50  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high.
- sample_tick  in  1  one-cycle sample strobe from codec clocking.
- cfg_load  in  1  one-cycle strobe that captures cfg_inc, cfg_amp and cfg_mode.
- cfg_inc  in  PHASE_W  new phase increment.
- cfg_amp  in  AMP_W  new amplitude.
- cfg_mode  in  2  new mode: 0 square, 1 saw, 2 triangle, 3 silence.
- cfg_busy  out  1  high while a captured configuration is pending.
- out  out  OUT_W  signed sample, held between updates.
- out_valid  out  1  one-cycle pulse when out updates.

## Operation
- Active registers: inc, amp, mode. Every cycle the accumulator updates as phase <= phase + inc, modulo 2^PHASE_W. The cycle where the add carries out is the wrap.
- inc = 0 freezes phase. The output remains valid and is constant.
- Config capture:
  - cfg_load writes the pending registers and sets cfg_busy.
  - A cfg_load while busy overwrites the pending values (last wins).
- Config apply: pending values are copied to active on a wrap cycle, or on the next cycle if active inc = 0 or active mode = 3. cfg_busy clears in the same edge.
- Simultaneous cfg_load and apply: the old pending values are applied, the new values become pending, and cfg_busy stays 1.
- Applying a configuration never resets phase.
- Normalised wave, with p = phase[PHASE_W-1 -: NORM_W+1]:
  - Saw: norm = p[NORM_W:1] with MSB inverted, covering -32768..32767.
  - Triangle: tu = p[NORM_W-1:0] if p[NORM_W]=0, else ~p[NORM_W-1:0]. norm = tu with MSB inverted. It rises during the first half period.
- Output value:
  - Square: out = +amp when phase MSB = 1, else -amp. This is exact and unscaled.
  - Saw and triangle: out = (norm × signed{0,amp}) >>> (NORM_W-1), arithmetic shift, sign-extended to OUT_W. norm = -32768 yields exactly -amp.
  - Silence: out = 0.
- Reset, including mid-operation:
  - phase = 0, inc = DEFAULT_INC, amp = DEFAULT_AMP, mode = 0.
  - Pending configuration is discarded and cfg_busy = 0.
  - out = 0, out_valid = 0, and in-flight samples are dropped.

## Timing
- Sample pipeline, two stages:
  - Edge after tick (T+1): phase, mode and amp are snapshotted.
  - T+2: out is registered and out_valid = 1 for exactly one cycle.
- Back-to-back ticks are fully pipelined; each tick yields one out_valid.
- A configuration applied at edge N affects snapshots taken at edge N+1 onward. A single sample never mixes old and new parameters.
- cfg_busy rises the edge after cfg_load. Its latency to clear is at most 2^PHASE_W / inc cycles.
- out holds its value when no tick occurs. out_valid is never high for two consecutive cycles unless the ticks are consecutive.

## Configuration
- TONE_GEN_TRIANGLE_EN:
  - Defined: mode 2 produces the triangle wave as specified above.
  - Undefined: the triangle fold logic is omitted and mode 2 behaves identically to mode 0 (square). All other behaviour is unchanged.

## Test plan
- Reset then 10 ticks, all defaults (inc 37_795, amp 10_000_000, mode 0) -> out alternates between ±10_000_000 with a half period of ≈56_818 cycles. Every out_valid arrives exactly 2 cycles after its tick.
- cfg_load inc=2^28, amp=1000, mode=1, tick every cycle -> after the next wrap, out ramps from -1000 toward 999 across 16 cycles, then drops to -1000.
- Mode 2 with inc=2^27, amp=32768 -> a 32-cycle triangle with peaks -32768 and +32767.
  - Without TONE_GEN_TRIANGLE_EN: output is a square wave at ±32768.
- Two cfg_loads while busy -> only the second configuration is applied at the wrap. cfg_busy stays high until that wrap, then clears.
- cfg_load coinciding with the apply cycle -> the old pending configuration is applied and cfg_busy stays 1. The new configuration is applied at the following wrap.
- Assert reset mid-pending while ticks are in flight -> the next cycle shows out=0, out_valid=0, cfg_busy=0. The phase restarts from 0 with the defaults.
